nbcac_6di_decoder_seq: RTL and testbench

- Sequential decoder for the 6-bit NBCAC code. It maps an 8-bit codeword d[8:1] back to the 6-bit data value v.
- Reconstruction rule: v = sum of S_i * d[i] over i = 1..8, where S = {1, 26, 16, 10, 6, 4, 2, 2}.
- Processes one codeword bit per clock through a bit-serial accumulator, with valid/ready handshakes on both sides.
- Sits on the receive side of a CAC-coded bus, after the wire sampler and before the data consumer. Also flags codewords whose weighted sum exceeds the 6-bit range.

---
 rtl/nbcac_6di_decoder_seq.sv | 138 +++++++++++++
 tb/tb_nbcac_6di_decoder_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/nbcac_6di_decoder_seq.sv
// rtl/nbcac_6di_decoder_seq.sv - bit-serial NBCAC 6-bit decoder with valid/ready handshakes
//
// Purpose: rebuilds the 6-bit value v = sum(S_i * d[i]) from an 8-bit NBCAC codeword.
// It takes one codeword bit per clock and flags codewords whose sum exceeds 2^VW-1.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - codeword present on in_code
//   in_ready  - decoder accepts a codeword this cycle (combinational from out_ready in OUT)
//   in_code   - codeword, bit 0 is d[1]
//   out_valid - decoded result available
//   out_ready - consumer takes the result this cycle
//   out_v     - decoded value (low VW bits of the weighted sum)
//   out_err   - weighted sum exceeded 2^VW-1
//   err_cnt   - saturating count of illegal codewords since reset

module nbcac_6di_decoder_seq #(
  parameter int VW = 6,
  parameter int CW = 8,
  parameter int AW = 8,
  parameter int S1 = 1,
  parameter int S2 = 26,
  parameter int S3 = 16,
  parameter int S4 = 10,
  parameter int S5 = 6,
  parameter int S6 = 4,
  parameter int S7 = 2,
  parameter int S8 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_v,
  output logic          out_err,
  output logic [7:0]    err_cnt
);

  localparam int BW = $clog2(CW);
  localparam logic [AW-1:0] MAXV = AW'((1 << VW) - 1);
  localparam logic [BW:0]   LAST = (BW + 1)'(CW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] code;
  logic [AW-1:0] acc;
  logic [BW:0]   idx;

  function automatic logic [AW-1:0] weight(input logic [BW-1:0] i);
    logic [AW-1:0] w;
    w = '0;
    case (i)
      0: w = AW'(S1);
      1: w = AW'(S2);
      2: w = AW'(S3);
      3: w = AW'(S4);
      4: w = AW'(S5);
      5: w = AW'(S6);
      6: w = AW'(S7);
      7: w = AW'(S8);
      default: w = '0;
    endcase
    return w;
  endfunction

  // A finishing consumer frees the decoder in the same cycle, so a new word
  // can be taken back-to-back with the result handoff.
  assign in_ready = (state == IDLE) | ((state == OUT) & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code      <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_v     <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            code  <= in_code;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end

        ACC: begin
          // idx 0..CW-1 add one weighted bit each; the cycle at idx == CW only
          // commits the finished sum, which places out_valid on the 9th edge.
          if (idx == LAST) begin
            out_v     <= acc[VW-1:0];
            out_err   <= (acc > MAXV);
            out_valid <= 1'b1;
            if ((acc > MAXV) && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
            state <= OUT;
          end else begin
            if (code[idx[BW-1:0]]) begin
              acc <= acc + weight(idx[BW-1:0]);
            end
            idx <= idx + 1'b1;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              code  <= in_code;
              acc   <= '0;
              idx   <= '0;
              state <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbcac_6di_decoder_seq.sv
// tb/tb_nbcac_6di_decoder_seq.sv - randomized self-checking bench for nbcac_6di_decoder_seq

module tb_nbcac_6di_decoder_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_v;
  logic       out_err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int wts [8] = '{1, 26, 16, 10, 6, 4, 2, 2};

  nbcac_6di_decoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_v     (out_v),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wsum(input logic [7:0] c);
    int s = 0;
    for (int i = 0; i < 8; i++) if (c[i]) s += wts[i];
    return s;
  endfunction

  // Called #1 after the transfer edge: waits for the result, stalls, then checks it.
  task automatic collect(input logic [7:0] c, input int stall);
    int n = 0;
    int s = wsum(c);
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    if (s > 63 && exp_cnt < 255) exp_cnt++;
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      chk("stall_v", out_v, s % 64);
      chk("stall_err", out_err, (s > 63) ? 1 : 0);
      chk("stall_in_ready", in_ready, 0);
      in_code = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
    end
    chk("out_v", out_v, s % 64);
    chk("out_err", out_err, (s > 63) ? 1 : 0);
    chk("err_cnt", err_cnt, exp_cnt);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    #0;
    chk("in_ready_out", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  task automatic send(input logic [7:0] c, input int stall);
    in_valid = 1'b1;
    in_code  = c;
    chk("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = 8'($urandom);
    chk("acc_in_ready", in_ready, 0);
    collect(c, stall);
    release_out();
  endtask

  initial begin
    logic [7:0] cands [$];
    logic [7:0] c;
    rst_n = 1'b0; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_v", out_v, 0);
    chk("rst_err", out_err, 0);
    chk("rst_cnt", err_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'h00, 0);
    send(8'h3F, 1);
    send(8'h01, 0);
    send(8'h1C, 2);

    for (int r = 0; r < 300; r++) send(8'hFF, 0);
    chk("cnt_sat", err_cnt, 255);

    // stall five cycles, then hand off and accept a new word in the same cycle
    in_valid = 1'b1; in_code = 8'h3F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(8'h3F, 5);
    out_ready = 1'b1; in_valid = 1'b1; in_code = 8'h01;
    #0;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_code = 8'hFF;
    chk("b2b_valid_drop", out_valid, 0);
    collect(8'h01, 0);
    release_out();

    // reset while in ACC at idx=4
    in_valid = 1'b1; in_code = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    send(8'h3F, 0);

    // every value 0..63 through one of its codewords
    for (int v = 0; v < 64; v++) begin
      cands.delete();
      for (int k = 0; k < 256; k++) if (wsum(8'(k)) == v) cands.push_back(8'(k));
      chk("has_codeword", (cands.size() > 0) ? 1 : 0, 1);
      if (cands.size() > 0) begin
        c = cands[$urandom_range(cands.size() - 1)];
        send(c, $urandom_range(3));
        chk("exh_v", out_v, v);
      end
    end

    for (int r = 0; r < 40; r++) begin
      c = 8'($urandom);
      send(c, $urandom_range(2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
